fp_mult_seq: RTL

Multi-cycle controller for the single-precision floating-point multiplier datapath.
- Accepts operand pairs and a per-operation rounding mode through a valid/ready handshake.
- Computes the 24x24 mantissa product on one shared iterative shift-add multiplier.
- Normalizes and rounds the product, handles special operands, and returns the IEEE-754 result plus status flags through a second valid/ready handshake.
- Sits between the operand source (CPU/testbench) and the result consumer; one operation in flight.

---
 rtl/fp_mult_seq.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/fp_mult_seq.sv
// fp_mult_seq: sequential binary32 multiplier controller.
// One operation in flight; mantissa product from an iterative shift-add
// multiplier, then normalize, round (6 modes) and range-check.
// Macro FP_MULT_SEQ_RADIX4_EN: retire two multiplier bits per MUL cycle
// (12 MUL cycles instead of 24); results are identical in both builds.
module fp_mult_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  rnd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] z,
    output logic [5:0]  flags
);

`ifdef FP_MULT_SEQ_RADIX4_EN
    localparam int         STEP     = 2;
    localparam logic [4:0] CNT_LAST = 5'd11;
`else
    localparam int         STEP     = 1;
    localparam logic [4:0] CNT_LAST = 5'd23;
`endif

    typedef enum logic [2:0] {IDLE, MUL, NORM, ROUND, SPEC, DONE} state_t;

    state_t             state, state_nxt;
    logic [30:0]        a_q, b_q;
    logic [2:0]         rnd_q;
    logic               sgn;
    logic [47:0]        ma_sh;   // multiplicand, pre-shifted to the current bit weight
    logic [23:0]        mb;      // multiplier, consumed from the LSB
    logic [47:0]        acc;
    logic [47:0]        pp;
    logic [4:0]         cnt;
    logic signed [9:0]  exp_q;
    logic [23:0]        mant;
    logic               grd, stk;

    // dispatch: exponent field 0 (zero/denormal) or 255 (inf/NaN) skips the multiplier
    logic in_special;
    assign in_special = (a[30:23] == 8'h00) || (a[30:23] == 8'hff) ||
                        (b[30:23] == 8'h00) || (b[30:23] == 8'hff);

    // partial product for this MUL cycle
`ifdef FP_MULT_SEQ_RADIX4_EN
    assign pp = ({48{mb[0]}} & ma_sh) + ({48{mb[1]}} & {ma_sh[46:0], 1'b0});
`else
    assign pp = {48{mb[0]}} & ma_sh;
`endif

    // rounding, carry-out renormalization and overflow/underflow handling
    logic               inc, inx;
    logic [24:0]        m25;
    logic [23:0]        mant_r;
    logic signed [9:0]  exp_r;
    logic [31:0]        z_rnd;
    logic [5:0]         f_rnd;
    always_comb begin
        inx = grd | stk;
        case (rnd_q)
            3'd1:    inc = 1'b0;
            3'd2:    inc = ~sgn & inx;
            3'd3:    inc = sgn & inx;
            3'd4:    inc = grd & (stk | ~sgn);   // a tie goes toward +inf
            3'd5:    inc = inx;
            default: inc = grd & (stk | mant[0]);
        endcase
        m25    = {1'b0, mant} + {24'd0, inc};
        mant_r = m25[24] ? m25[24:1] : m25[23:0];
        exp_r  = exp_q + (m25[24] ? 10'sd1 : 10'sd0);
        z_rnd  = {sgn, exp_r[7:0], mant_r[22:0]};
        f_rnd  = {inx, 5'b00000};
        if (exp_r >= 10'sd255) begin
            f_rnd = 6'b110000;
            case (rnd_q)
                3'd1:    z_rnd = {sgn, 31'h7f7fffff};
                3'd2:    z_rnd = sgn ? 32'hff7fffff : 32'h7f800000;
                3'd3:    z_rnd = sgn ? 32'hff800000 : 32'h7f7fffff;
                default: z_rnd = {sgn, 31'h7f800000};
            endcase
            if (z_rnd[30:0] == 31'h7f800000) f_rnd[1] = 1'b1;
        end else if (exp_r <= 10'sd0) begin
            z_rnd = {sgn, 31'd0};
            f_rnd = 6'b101001;
        end
    end

    // special operands; denormals count as zero
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [31:0] z_spec;
    logic [5:0]  f_spec;
    always_comb begin
        a_zero = (a_q[30:23] == 8'h00);
        b_zero = (b_q[30:23] == 8'h00);
        a_inf  = (a_q[30:23] == 8'hff) && (a_q[22:0] == 23'd0);
        b_inf  = (b_q[30:23] == 8'hff) && (b_q[22:0] == 23'd0);
        a_nan  = (a_q[30:23] == 8'hff) && (a_q[22:0] != 23'd0);
        b_nan  = (b_q[30:23] == 8'hff) && (b_q[22:0] != 23'd0);
        z_spec = {sgn, 31'd0};
        f_spec = 6'b000001;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            z_spec = 32'h7fc00000;
            f_spec = 6'b000100;
        end else if (a_inf || b_inf) begin
            z_spec = {sgn, 8'hff, 23'd0};
            f_spec = 6'b000010;
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // next state and handshake outputs (decoded from state only)
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = in_special ? SPEC : MUL;
            end
            MUL:   if (cnt == CNT_LAST) state_nxt = NORM;
            NORM:  state_nxt = ROUND;
            ROUND: state_nxt = DONE;
            SPEC:  state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // datapath registers; z/flags only change when a result is produced
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q <= '0; b_q <= '0; rnd_q <= '0; sgn <= 1'b0;
            ma_sh <= '0; mb <= '0; acc <= '0; cnt <= '0;
            exp_q <= '0; mant <= '0; grd <= 1'b0; stk <= 1'b0;
            z <= '0; flags <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q   <= a[30:0];
                    b_q   <= b[30:0];
                    rnd_q <= rnd;
                    sgn   <= a[31] ^ b[31];
                    ma_sh <= {24'd0, 1'b1, a[22:0]};
                    mb    <= {1'b1, b[22:0]};
                    acc   <= '0;
                    cnt   <= '0;
                    exp_q <= $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
                end
                MUL: begin
                    acc   <= acc + pp;
                    ma_sh <= ma_sh << STEP;
                    mb    <= mb >> STEP;
                    cnt   <= cnt + 5'd1;
                end
                NORM: begin
                    if (acc[47]) begin
                        mant  <= acc[47:24];
                        grd   <= acc[23];
                        stk   <= |acc[22:0];
                        exp_q <= exp_q + 10'sd1;
                    end else begin
                        mant  <= acc[46:23];
                        grd   <= acc[22];
                        stk   <= |acc[21:0];
                    end
                end
                ROUND: begin
                    z     <= z_rnd;
                    flags <= f_rnd;
                end
                SPEC: begin
                    z     <= z_spec;
                    flags <= f_spec;
                end
                default: ;
            endcase
        end
    end

endmodule
